// File: rtl/rotation_vec_ctrl.sv
// Rotation sequencer: one keypoint angle in, NCHUNK ROM slice reads, assembles
// the rotated x/y pattern vector and hands it downstream on valid/ready.
module rotation_vec_ctrl #(
  parameter int BW_XCOS = 11,
  parameter int BW_OUT  = 6,
  parameter int N_PAIRS = 128,
  parameter int CHUNK   = 32,
  parameter int N_ANG   = 30,
  parameter int ANG_W   = 5,
  parameter int ADDR_W  = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      kp_valid,
  output logic                      kp_ready,
  input  logic [ANG_W-1:0]          kp_angle,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [CHUNK*BW_OUT-1:0]   rs_x,
  input  logic [CHUNK*BW_OUT-1:0]   rs_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_PAIRS*BW_OUT-1:0] out_x,
  output logic [N_PAIRS*BW_OUT-1:0] out_y,
  output logic [ANG_W-1:0]          out_angle,
  output logic                      out_err
);
  localparam int NCHUNK = N_PAIRS / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int SW     = CHUNK * BW_OUT;
  localparam int VW     = N_PAIRS * BW_OUT;
  localparam logic [ANG_W-1:0] ANG_MAX = ANG_W'(N_ANG - 1);
  localparam logic [CW-1:0]    LAST    = CW'(NCHUNK - 1);
  localparam logic [CW-1:0]    NCH     = CW'(NCHUNK);

  if (N_PAIRS % CHUNK != 0 || BW_XCOS < 1 || (1 << ADDR_W) < N_ANG * NCHUNK) begin : g_bad_param
    $error("rotation_vec_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;

  logic [ANG_W-1:0] angle_q, angle_d, out_angle_q, out_angle_d;
  logic             err_q, err_d, out_err_q, out_err_d;
  logic [CW-1:0]    issue_q, issue_d, cap_idx_q, cap_idx_d;
  logic             cap_vld_q, cap_vld_d, out_valid_q, out_valid_d;
  logic [VW-1:0]    out_x_q, out_x_d, out_y_q, out_y_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      angle_q     <= '0;
      err_q       <= 1'b0;
      issue_q     <= '0;
      cap_idx_q   <= '0;
      cap_vld_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_angle_q <= '0;
      out_err_q   <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      angle_q     <= angle_d;
      err_q       <= err_d;
      issue_q     <= issue_d;
      cap_idx_q   <= cap_idx_d;
      cap_vld_q   <= cap_vld_d;
      out_valid_q <= out_valid_d;
      out_angle_q <= out_angle_d;
      out_err_q   <= out_err_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (kp_valid) state_d = RUN;
      RUN:     if (cap_vld_q && cap_idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    kp_ready  = (state_q == IDLE) && !rst;
    rom_en    = (state_q == RUN) && (issue_q < NCH) && !rst;
    rom_addr  = ADDR_W'(int'(angle_q) * NCHUNK + int'(issue_q));
    out_valid = out_valid_q;
    out_angle = out_angle_q;
    out_err   = out_err_q;
    out_x     = out_x_q;
    out_y     = out_y_q;
  end

  // ROM data lands one cycle after the strobe, so capture trails issue by one.
  always_comb begin
    angle_d     = angle_q;
    err_d       = err_q;
    issue_d     = issue_q;
    cap_vld_d   = rom_en;
    cap_idx_d   = issue_q;
    out_valid_d = out_valid_q;
    out_angle_d = out_angle_q;
    out_err_d   = out_err_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    if (state_q == IDLE && kp_valid) begin
      err_d   = kp_angle > ANG_MAX;
      angle_d = err_d ? '0 : kp_angle;
      issue_d = '0;
    end
    if (rom_en) issue_d = issue_q + 1'b1;
    if (cap_vld_q) begin
      out_x_d[int'(cap_idx_q)*SW +: SW] = rs_x;
      out_y_d[int'(cap_idx_q)*SW +: SW] = rs_y;
      if (cap_idx_q == LAST) begin
        out_valid_d = 1'b1;
        out_angle_d = angle_q;
        out_err_d   = err_q;
      end
    end
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
  end
endmodule

// File: tb/tb_rotation_vec_ctrl.sv
// Directed bench for rotation_vec_ctrl with a behavioural ROM + add/sub slice model.
module tb_rotation_vec_ctrl;
  localparam int BW_OUT = 6, N_PAIRS = 128, CHUNK = 32, NCHUNK = 4;
  localparam int ANG_W = 5, ADDR_W = 7, SW = CHUNK*BW_OUT, VW = N_PAIRS*BW_OUT;

  logic              clk = 1'b0;
  logic              rst, kp_valid, kp_ready, rom_en, out_valid, out_ready, out_err;
  logic [ANG_W-1:0]  kp_angle, out_angle;
  logic [ADDR_W-1:0] rom_addr;
  logic [SW-1:0]     rs_x, rs_y;
  logic [VW-1:0]     out_x, out_y;

  rotation_vec_ctrl dut (
    .clk(clk), .rst(rst), .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_angle(kp_angle),
    .rom_en(rom_en), .rom_addr(rom_addr), .rs_x(rs_x), .rs_y(rs_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_angle(out_angle), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  task automatic chk(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ROM + datapath model: slice k pair i -> x = k*CHUNK+i, y = x + angle (mod 2^BW_OUT)
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_vld = 1'b0;
  always @(posedge clk) begin
    rd_vld <= rom_en;
    if (rom_en) rd_addr <= rom_addr;
  end
  always_comb begin
    rs_x = 'x;
    rs_y = 'x;
    if (rd_vld)
      for (int i = 0; i < CHUNK; i++) begin
        rs_x[i*BW_OUT +: BW_OUT] = BW_OUT'((int'(rd_addr) % NCHUNK) * CHUNK + i);
        rs_y[i*BW_OUT +: BW_OUT] = BW_OUT'((int'(rd_addr) % NCHUNK) * CHUNK + i + int'(rd_addr) / NCHUNK);
      end
  end

  function automatic logic [VW-1:0] exp_vec(input int ang);
    logic [VW-1:0] v;
    for (int p = 0; p < N_PAIRS; p++) v[p*BW_OUT +: BW_OUT] = BW_OUT'(p + ang);
    return v;
  endfunction

  int                cyc = 0;
  int                acc_cyc[$];
  logic [ADDR_W-1:0] addr_log[$];
  logic [ANG_W-1:0]  done_ang[$];
  always @(posedge clk) begin
    if (kp_valid && kp_ready) acc_cyc.push_back(cyc);
    if (rom_en) addr_log.push_back(rom_addr);
    if (out_valid && out_ready) done_ang.push_back(out_angle);
    cyc <= cyc + 1;
  end

  task automatic offer(input logic [ANG_W-1:0] ang, input bit hold);
    int n;
    n = acc_cyc.size();
    @(negedge clk);
    kp_valid = 1'b1;
    kp_angle = ang;
    for (int k = 0; k < 40 && acc_cyc.size() == n; k++) @(negedge clk);
    chk("accept", acc_cyc.size(), n + 1);
    if (!hold) kp_valid = 1'b0;
  endtask

  // returns edges from accept to out_valid rise
  task automatic wait_valid(output int lat);
    for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
    lat = out_valid ? cyc - 1 - acc_cyc[acc_cyc.size()-1] : -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, stable, rdy, c, n, k, low, gap1, gap2, bad;
    logic [VW-1:0] sx, sy;
    logic [ADDR_W-1:0] exp_a[$];
    rst = 1'b1; kp_valid = 1'b0; kp_angle = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_kp_ready", kp_ready, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_kp_ready_after", kp_ready, 1);

    // T2 single keypoint
    addr_log.delete();
    offer(5'd3, 1'b0);
    wait_valid(lat);
    chk("t2_latency", lat, NCHUNK + 1);
    chk("t2_addr_cnt", addr_log.size(), 4);
    chk("t2_addrs", {addr_log[0], addr_log[1], addr_log[2], addr_log[3]}, {7'd12, 7'd13, 7'd14, 7'd15});
    chk("t2_out_x", out_x, exp_vec(0));
    chk("t2_out_y", out_y, exp_vec(3));
    chk("t2_angle", out_angle, 3);
    chk("t2_err", out_err, 0);
    @(negedge clk);
    chk("t2_consumed", {out_valid, kp_ready}, 2'b01);

    // T3 backpressure with a pending keypoint that must not be lost
    out_ready = 1'b0;
    offer(5'd10, 1'b0);
    wait_valid(lat);
    chk("t3_latency", lat, NCHUNK + 1);
    sx = out_x; sy = out_y;
    kp_valid = 1'b1; kp_angle = 5'd5;
    stable = 0; rdy = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid && out_x === sx && out_y === sy && out_angle == 5'd10) stable++;
      if (kp_ready) rdy++;
    end
    chk("t3_stable", stable, 10);
    chk("t3_kp_ready_low", rdy, 0);
    chk("t3_out_y", out_y, exp_vec(10));
    out_ready = 1'b1;
    c = cyc; n = acc_cyc.size();
    repeat (2) @(negedge clk);
    chk("t3_acc_cnt", acc_cyc.size(), n + 1);
    chk("t3_acc_edge", acc_cyc[acc_cyc.size()-1], c + 1);
    kp_valid = 1'b0;
    wait_valid(lat);
    chk("t3_held_angle", out_angle, 5);
    chk("t3_held_y", out_y, exp_vec(5));
    @(negedge clk);

    // T4 illegal angle then the top legal angle
    addr_log.delete();
    offer(5'd31, 1'b0);
    wait_valid(lat);
    chk("t4_addrs", {addr_log[0], addr_log[1], addr_log[2], addr_log[3]}, {7'd0, 7'd1, 7'd2, 7'd3});
    chk("t4_err", out_err, 1);
    chk("t4_angle", out_angle, 0);
    chk("t4_out_y", out_y, exp_vec(0));
    addr_log.delete();
    offer(5'd29, 1'b0);
    wait_valid(lat);
    chk("t4b_addrs", {addr_log[0], addr_log[1], addr_log[2], addr_log[3]}, {7'd116, 7'd117, 7'd118, 7'd119});
    chk("t4b_err", out_err, 0);
    chk("t4b_out_y", out_y, exp_vec(29));
    @(negedge clk);

    // T5 back-to-back with kp_valid held high
    addr_log.delete(); done_ang.delete();
    @(negedge clk);
    kp_valid = 1'b1; kp_angle = 5'd0;
    n = acc_cyc.size(); k = 0; low = 0; gap1 = -1; gap2 = -1;
    for (int t = 0; t < 60 && k < 3; t++) begin
      @(negedge clk);
      if (acc_cyc.size() > n + k) begin
        k++;
        if (k == 2) gap1 = low;
        if (k == 3) gap2 = low;
        low = 0;
        kp_angle = (k == 1) ? 5'd29 : 5'd7;
        if (k == 3) kp_valid = 1'b0;
      end
      if (!kp_ready) low++;
    end
    chk("t5_accepts", k, 3);
    chk("t5_busy_gap1", gap1, NCHUNK + 2);
    chk("t5_busy_gap2", gap2, NCHUNK + 2);
    for (int t = 0; t < 40 && done_ang.size() < 3; t++) @(negedge clk);
    chk("t5_order", {done_ang[0], done_ang[1], done_ang[2]}, {5'd0, 5'd29, 5'd7});
    chk("t5_last_y", out_y, exp_vec(7));
    exp_a = '{0, 1, 2, 3, 116, 117, 118, 119, 28, 29, 30, 31};
    bad = 0;
    foreach (exp_a[i]) if (i >= addr_log.size() || addr_log[i] !== exp_a[i]) bad++;
    chk("t5_addr_cnt", addr_log.size(), 12);
    chk("t5_addr_seq_bad", bad, 0);

    // T1 reset mid-RUN
    offer(5'd12, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rom_en", rom_en, 0);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_out_x", out_x, 0);
    chk("t1_out_angle_err", {out_angle, out_err}, 0);
    chk("t1_kp_ready", kp_ready, 1);
    rdy = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || rom_en) rdy++;
    end
    chk("t1_no_partial", rdy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
